// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: opcode field, NOP word, immediate-opcode
// mask default and the fetch FSM state encoding.
package fetch_stage_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;

    localparam logic [15:0] NOP_INSTR       = 16'h0000;
    localparam logic [15:0] IMM_OPCODES_DEF = 16'h1C00;

    typedef enum logic [1:0] {
        VEC_LO,
        VEC_HI,
        RUN
    } fetchState_t;

    // Opcode nibble of an instruction word
    function automatic logic [3:0] opcodeOf(input logic [15:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or insert a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            bubble,
    input  logic [15:0]     instrIn,
    input  logic [PC_W-1:0] pcIn,
    input  logic            immIn,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            valid,
    output logic            imm
);

    // Bubble wins over load; neither means hold (stall)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
            imm   <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
            imm   <= 1'b0;
        end else if (load) begin
            instr <= instrIn;
            pc    <= pcIn;
            valid <= 1'b1;
            imm   <= immIn;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: two-cycle reset-vector load, then one word per cycle,
// with stall/redirect handling and tagging of immediate words for decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          PC_W        = 32,
    parameter logic [15:0] IMM_OPCODES = IMM_OPCODES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc,
    output logic            if_id_valid,
    output logic            if_id_imm
);

    fetchState_t     state;
    logic [PC_W-1:0] pc;
    logic            immPending;
    logic            inRun;
    logic            load;
    logic            bubble;

    assign inRun  = (state == RUN);
    // Redirect overrides stall; the vector states keep IF/ID empty
    assign bubble = !inRun || redirect_valid;
    assign load   = inRun && !redirect_valid && !stall;

    // Memory address: vector words 0/1 during load, pc afterwards
    always_comb begin
        imem_addr = pc;
        case (state)
            VEC_LO:  imem_addr = '0;
            VEC_HI:  imem_addr = PC_W'(1);
            default: imem_addr = pc;
        endcase
    end

    // Fetch FSM, PC and pending-immediate tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= VEC_LO;
            pc         <= '0;
            immPending <= 1'b0;
        end else begin
            case (state)
                VEC_LO: begin
                    pc    <= PC_W'(imem_data);
                    state <= VEC_HI;
                end
                VEC_HI: begin
                    pc    <= PC_W'({imem_data, pc[15:0]});
                    state <= RUN;
                end
                RUN: begin
                    if (redirect_valid) begin
                        pc         <= redirect_pc;
                        immPending <= 1'b0;
                    end else if (!stall) begin
                        pc         <= pc + PC_W'(1);
                        // an immediate word never arms the tag, so data is not chained
                        immPending <= !immPending && IMM_OPCODES[opcodeOf(imem_data)];
                    end
                end
                default: state <= VEC_LO;
            endcase
        end
    end

    if_id_reg #(.PC_W(PC_W)) uIfId (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .bubble  (bubble),
        .instrIn (imem_data),
        .pcIn    (pc),
        .immIn   (immPending),
        .instr   (if_id_instr),
        .pc      (if_id_pc),
        .valid   (if_id_valid),
        .imm     (if_id_imm)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    typedef struct {
        logic [15:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        imm;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        if_id_imm;

    logic [15:0] mem [256];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .if_id_imm      (if_id_imm)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, o, e);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] i, input logic [31:0] p,
                                input logic v, input logic im, input logic [31:0] a);
        exp_t e;
        e.instr = i; e.pc = p; e.valid = v; e.imm = im; e.addr = a;
        return e;
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge state, compare after the edge
    task automatic step(input string tag, input logic st, input logic rv,
                        input logic [31:0] rp, input exp_t e);
        exp_t g;
        stall = st; redirect_valid = rv; redirect_pc = rp;
        sb.push_back(e);
        @(posedge clk); #1;
        g = sb.pop_front();
        chk({tag, ".instr"}, 32'(if_id_instr), 32'(g.instr));
        chk({tag, ".pc"},    if_id_pc,         g.pc);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(g.valid));
        chk({tag, ".imm"},   32'(if_id_imm),   32'(g.imm));
        chk({tag, ".addr"},  imem_addr,        g.addr);
    endtask

    task automatic checkCleared(input string tag);
        chk({tag, ".instr"}, 32'(if_id_instr), 32'h0);
        chk({tag, ".pc"},    if_id_pc,         32'h0);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, ".imm"},   32'(if_id_imm),   32'h0);
        chk({tag, ".addr"},  imem_addr,        32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0010;
        mem[8'h01] = 16'h0000;
        mem[8'h10] = 16'hC123;
        mem[8'h11] = 16'hC000;
        mem[8'h12] = 16'h1000;
        mem[8'h13] = 16'hA000;
        mem[8'h14] = 16'h7777;
        mem[8'h40] = 16'h1234;
        mem[8'h41] = 16'h5678;
        mem[8'hFF] = 16'h00FF;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        checkCleared("reset");
        reset = 1'b0;

        // vector load
        step("vec_lo", 0, 0, 0, mk(16'h0, 32'h0, 0, 0, 32'h1));
        step("vec_hi", 0, 0, 0, mk(16'h0, 32'h0, 0, 0, 32'h10));
        step("run10",  0, 0, 0, mk(16'hC123, 32'h10, 1, 0, 32'h11));
        step("run11",  0, 0, 0, mk(16'hC000, 32'h11, 1, 1, 32'h12));
        // stall three cycles at pc 0x12
        step("stall1", 1, 0, 0, mk(16'hC000, 32'h11, 1, 1, 32'h12));
        step("stall2", 1, 0, 0, mk(16'hC000, 32'h11, 1, 1, 32'h12));
        step("stall3", 1, 0, 0, mk(16'hC000, 32'h11, 1, 1, 32'h12));
        step("run12",  0, 0, 0, mk(16'h1000, 32'h12, 1, 0, 32'h13));
        // A000 arms the tag, then redirect+stall drops it
        step("run13",  0, 0, 0, mk(16'hA000, 32'h13, 1, 0, 32'h14));
        step("redir",  1, 1, 32'h40, mk(16'h0, 32'h0, 0, 0, 32'h40));
        step("run40",  0, 0, 0, mk(16'h1234, 32'h40, 1, 0, 32'h41));
        step("run41",  0, 0, 0, mk(16'h5678, 32'h41, 1, 0, 32'h42));
        // wrap
        step("redirW", 0, 1, 32'hFFFF_FFFF, mk(16'h0, 32'h0, 0, 0, 32'hFFFF_FFFF));
        step("runFF",  0, 0, 0, mk(16'h00FF, 32'hFFFF_FFFF, 1, 0, 32'h0));
        step("run00",  0, 0, 0, mk(16'h0010, 32'h0, 1, 0, 32'h1));

        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1 checkCleared("midreset");
        #1 reset = 1'b0;
        step("re_lo", 0, 0, 0, mk(16'h0, 32'h0, 0, 0, 32'h1));
        step("re_hi", 0, 0, 0, mk(16'h0, 32'h0, 0, 0, 32'h10));
        step("re10",  0, 0, 0, mk(16'hC123, 32'h10, 1, 0, 32'h11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
